// File: rtl/clint_trap_sequencer_pkg.sv
// Shared definitions for the machine-mode trap sequencer: CSR addresses, mstatus
// bit positions, cause codes, FSM states and the pure CSR/target helper functions.
package clint_trap_sequencer_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam int unsigned MSTATUS_MIE  = 3;
  localparam int unsigned MSTATUS_MPIE = 7;

  localparam logic [31:0] CAUSE_M_EXT   = 32'h8000_000B;
  localparam logic [31:0] CAUSE_M_TIMER = 32'h8000_0007;
  localparam logic [31:0] CAUSE_ECALL_M = 32'd11;

  localparam logic [1:0] MTVEC_MODE_VECTORED = 2'd1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ENT_EPC,
    ST_ENT_CAUSE,
    ST_ENT_STAT,
    ST_ENT_JUMP,
    ST_RET_STAT,
    ST_RET_JUMP
  } state_e;

  function automatic logic [31:0] align4(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

  // Vectored mode only applies to interrupts; synchronous traps always use the base.
  function automatic logic [31:0] trap_target(input logic [31:0] mtvec,
                                              input logic [31:0] cause,
                                              input logic        is_irq);
    logic [31:0] base;
    base = align4(mtvec);
    if (is_irq && (mtvec[1:0] == MTVEC_MODE_VECTORED))
      return base + {25'd0, cause[4:0], 2'b00};
    return base;
  endfunction

  function automatic logic [31:0] mstatus_on_entry(input logic [31:0] mstatus);
    logic [31:0] r;
    r               = mstatus;
    r[MSTATUS_MPIE] = mstatus[MSTATUS_MIE];
    r[MSTATUS_MIE]  = 1'b0;
    return r;
  endfunction

  function automatic logic [31:0] mstatus_on_return(input logic [31:0] mstatus);
    logic [31:0] r;
    r               = mstatus;
    r[MSTATUS_MIE]  = mstatus[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/clint_trap_sequencer.sv
// Trap-entry / trap-return sequencer: walks the CSR write port through
// mepc/mcause/mstatus updates while stalling, then redirects and flushes.
module clint_trap_sequencer
  import clint_trap_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ext_irq,
  input  logic        timer_irq,
  input  logic        ecall_id,
  input  logic        mret_id,
  input  logic [31:0] epc_in,
  input  logic        interrupt_enable,
  input  logic [31:0] clint_csr_mstatus,
  input  logic [31:0] clint_csr_mepc,
  input  logic [31:0] clint_csr_mtvec,
  input  logic        csr_we_ex,
  output logic        we_clint,
  output logic [11:0] wa_clint,
  output logic [31:0] wd_clint,
  output logic        stall,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        trap_ack
);

  state_e      state;
  logic [31:0] epc_q;
  logic [31:0] cause_q;
  logic        irq_q;

  logic take_irq;
  logic accept;

  assign take_irq = interrupt_enable && (ext_irq || timer_irq);
  assign accept   = !rst && (state == ST_IDLE) && (take_irq || ecall_id || mret_id);
  assign trap_ack = accept;

  // NOTE: state and latched request data use non-blocking assignments so every
  // register samples pre-edge values; blocking here would create order races.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      epc_q   <= 32'd0;
      cause_q <= 32'd0;
      irq_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (take_irq) begin
            epc_q   <= epc_in;
            cause_q <= ext_irq ? CAUSE_M_EXT : CAUSE_M_TIMER;
            irq_q   <= 1'b1;
            state   <= ST_ENT_EPC;
          end else if (ecall_id) begin
            epc_q   <= epc_in;
            cause_q <= CAUSE_ECALL_M;
            irq_q   <= 1'b0;
            state   <= ST_ENT_EPC;
          end else if (mret_id) begin
            state   <= ST_RET_STAT;
          end
        end
        // Write states hold while EX owns the CSR write port.
        ST_ENT_EPC:   if (!csr_we_ex) state <= ST_ENT_CAUSE;
        ST_ENT_CAUSE: if (!csr_we_ex) state <= ST_ENT_STAT;
        ST_ENT_STAT:  if (!csr_we_ex) state <= ST_ENT_JUMP;
        ST_ENT_JUMP:  state <= ST_IDLE;
        ST_RET_STAT:  if (!csr_we_ex) state <= ST_RET_JUMP;
        ST_RET_JUMP:  state <= ST_IDLE;
        default:      state <= ST_IDLE;
      endcase
    end
  end

  // NOTE: every output gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    we_clint       = 1'b0;
    wa_clint       = 12'd0;
    wd_clint       = 32'd0;
    stall          = 1'b0;
    flush          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    if (!rst) begin
      stall = (state != ST_IDLE);
      case (state)
        ST_ENT_EPC: if (!csr_we_ex) begin
          we_clint = 1'b1;
          wa_clint = CSR_MEPC;
          wd_clint = epc_q;
        end
        ST_ENT_CAUSE: if (!csr_we_ex) begin
          we_clint = 1'b1;
          wa_clint = CSR_MCAUSE;
          wd_clint = cause_q;
        end
        // mstatus is read live so an earlier EX write to it is not lost.
        ST_ENT_STAT: if (!csr_we_ex) begin
          we_clint = 1'b1;
          wa_clint = CSR_MSTATUS;
          wd_clint = mstatus_on_entry(clint_csr_mstatus);
        end
        ST_RET_STAT: if (!csr_we_ex) begin
          we_clint = 1'b1;
          wa_clint = CSR_MSTATUS;
          wd_clint = mstatus_on_return(clint_csr_mstatus);
        end
        ST_ENT_JUMP: begin
          flush          = 1'b1;
          redirect_valid = 1'b1;
          redirect_pc    = trap_target(clint_csr_mtvec, cause_q, irq_q);
        end
        ST_RET_JUMP: begin
          flush          = 1'b1;
          redirect_valid = 1'b1;
          redirect_pc    = align4(clint_csr_mepc);
        end
        default: ;
      endcase
    end
  end

endmodule
